pong_update_sched: RTL and testbench

PONG_UPDATE_SCHED -- requirements
Module: pong_update_sched

---
 rtl/pong_update_sched.sv | 117 +++++++++++
 tb/tb_pong_update_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_update_sched.sv
// pong_update_sched: launches the per-frame game-update step sequence every FRAME_DIV vblanks; `PONG_SCHED_TIMEOUT_EN adds a WAIT timeout.
// Latency: step_go one cycle after the launching vblank_start; each step waits on step_done, and vblanks arriving while busy are dropped.
module pong_update_sched #(
    parameter int FRAME_DIV = 1,
    parameter int TIMEOUT   = 1024
) (
    input  logic       clk_50Mhz,
    input  logic       rst,
    input  logic       vblank_start,
    input  logic       pause,
    input  logic       step_done,
    input  logic       clr_err,
    output logic       step_go,
    output logic [2:0] step_id,
    output logic       busy,
    output logic       seq_done,
    output logic [7:0] frame_cnt,
    output logic       overrun,
    output logic       err_timeout
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [2:0] LAST_STEP = 3'd4;
    localparam logic [7:0] DIV_LAST  = 8'(FRAME_DIV - 1);

    state_t     state;
    logic [7:0] div_cnt;
    logic       pause_q;
    logic       tmo_hit;
    logic       step_ack;

`ifdef PONG_SCHED_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt;

    assign tmo_hit = (state == S_WAIT) && !step_done && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == S_ISSUE)
                tmo_cnt <= '0;
            else if (state == S_WAIT)
                tmo_cnt <= tmo_cnt + 16'd1;
            // A new timeout beats a simultaneous clear.
            if (tmo_hit)
                err_timeout <= 1'b1;
            else if (clr_err)
                err_timeout <= 1'b0;
        end
    end
`else
    // No counter is built, so a step can never be abandoned.
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0 && (TIMEOUT > 1);
`endif

    assign step_ack = (state == S_WAIT) && (step_done || tmo_hit);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            state     <= S_IDLE;
            step_go   <= 1'b0;
            step_id   <= 3'd0;
            seq_done  <= 1'b0;
            frame_cnt <= 8'd0;
            div_cnt   <= 8'd0;
            pause_q   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            step_go  <= 1'b0;
            seq_done <= 1'b0;

            if (vblank_start && (state != S_IDLE))
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (vblank_start) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt   <= 8'd0;
                            pause_q   <= pause;
                            frame_cnt <= frame_cnt + 8'd1;
                            step_id   <= 3'd0;
                            step_go   <= 1'b1;
                            state     <= S_ISSUE;
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (step_ack) begin
                        // Paused frames only sample the controls.
                        if (pause_q || (step_id == LAST_STEP)) begin
                            step_id  <= 3'd0;
                            seq_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            step_id <= step_id + 3'd1;
                            step_go <= 1'b1;
                            state   <= S_ISSUE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pong_update_sched.sv
// Bench for pong_update_sched: scoreboard of expected step ids and frame counts, auto-acking responder.
module tb_pong_update_sched;
    logic       clk = 1'b0;
    logic       rst, vblank_start, pause, step_done, clr_err;
    logic       step_go, busy, seq_done, overrun, err_timeout;
    logic [2:0] step_id;
    logic [7:0] frame_cnt;

    logic       vb3, sd3, p3, c3, go3, busy3, sdn3, ov3, et3;
    logic [2:0] id3;
    logic [7:0] fc3;

    int         n_checks = 0;
    int         n_errors = 0;
    int         step_q[$];
    logic [7:0] frame_q[$];
    logic [7:0] exp_frame;
    int         ack_delay = 3;
    int         ack_cnt = 0;
    bit         skip_en = 1'b0;
    logic [2:0] skip_id = 3'd0;
    int         seq3 = 0;

    always #10 clk = ~clk;

    pong_update_sched #(.FRAME_DIV(1), .TIMEOUT(16)) dut (
        .clk_50Mhz(clk), .rst(rst), .vblank_start(vblank_start), .pause(pause),
        .step_done(step_done), .clr_err(clr_err), .step_go(step_go), .step_id(step_id),
        .busy(busy), .seq_done(seq_done), .frame_cnt(frame_cnt), .overrun(overrun),
        .err_timeout(err_timeout)
    );

    pong_update_sched #(.FRAME_DIV(3), .TIMEOUT(16)) dut3 (
        .clk_50Mhz(clk), .rst(rst), .vblank_start(vb3), .pause(p3),
        .step_done(sd3), .clr_err(c3), .step_go(go3), .step_id(id3),
        .busy(busy3), .seq_done(sdn3), .frame_cnt(fc3), .overrun(ov3),
        .err_timeout(et3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard side: pop expectations as the DUT produces step strobes and sequence ends.
    initial forever begin
        @(negedge clk);
        if (step_go) begin
            if (step_q.size() == 0) check_eq("step_unexpected", 32'(step_id), 32'hFFFF);
            else check_eq("step_id", 32'(step_id), 32'(step_q.pop_front()));
        end
        if (seq_done) begin
            if (frame_q.size() == 0) check_eq("seq_unexpected", 32'(frame_cnt), 32'hFFFF);
            else check_eq("seq_frame", 32'(frame_cnt), 32'(frame_q.pop_front()));
        end
    end

    // Responder: step_done ack_delay cycles after each step_go, unless that step is being starved.
    initial begin
        step_done = 1'b0;
        forever begin
            @(negedge clk);
            step_done = 1'b0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) step_done = 1'b1;
            end
            if (step_go && !(skip_en && step_id == skip_id)) ack_cnt = ack_delay;
        end
    end

    // Immediate acknowledge for the divide-by-3 instance.
    initial begin
        logic go_prev;
        go_prev = 1'b0;
        sd3 = 1'b0;
        forever begin
            @(negedge clk);
            sd3 = go_prev;
            go_prev = go3;
            if (sdn3) seq3++;
        end
    end

    task automatic launch(input bit p);
        pause = p;
        vblank_start = 1'b1;
        exp_frame++;
        frame_q.push_back(exp_frame);
        if (p) step_q.push_back(0);
        else for (int i = 0; i < 5; i++) step_q.push_back(i);
        @(negedge clk);
        vblank_start = 1'b0;
        check_eq("launch_go", 32'(step_go), 32'd1);
    endtask

    task automatic wait_seq_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (seq_done) begin
                check_eq("busy_in_done", 32'(busy), 32'd1);
                @(negedge clk);
                check_eq("busy_fall", 32'(busy), 32'd0);
                return;
            end
        end
        check_eq("seq_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_step(input logic [2:0] id, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (step_go && step_id == id) return;
        end
        check_eq("step_wait_timeout", 32'(id), 32'hFFFF);
    endtask

    task automatic pulse3(input bit extra);
        vb3 = 1'b1;
        @(negedge clk);
        vb3 = 1'b0;
        if (extra) begin
            vb3 = 1'b1;
            @(negedge clk);
            vb3 = 1'b0;
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: got still running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; vblank_start = 1'b1; pause = 1'b0; clr_err = 1'b0;
        vb3 = 1'b0; p3 = 1'b0; c3 = 1'b0; exp_frame = 8'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_step_go", 32'(step_go), 32'd0);
        check_eq("rst_step_id", 32'(step_id), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_seq_done", 32'(seq_done), 32'd0);
        check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        check_eq("rst_err_timeout", 32'(err_timeout), 32'd0);
        check_eq("rst_fc3", 32'(fc3), 32'd0);
        rst = 1'b0;
        vblank_start = 1'b0;
        @(negedge clk);

        // Divide-by-3: launches on pulses 3, 6, 9, 12; an overrun pulse after 9 must not advance the divider.
        for (int k = 1; k <= 12; k++) begin
            pulse3(k == 9);
            check_eq("div3_frame", 32'(fc3), 32'(k / 3));
            if (k == 6) check_eq("div3_seq_count", 32'(seq3), 32'd2);
        end
        check_eq("div3_seq_total", 32'(seq3), 32'd4);
        check_eq("div3_overrun", 32'(ov3), 32'd1);

        // Full sequence, acks 3 cycles after each step_go.
        launch(1'b0);
        wait_seq_done(100);
        check_eq("full_frame", 32'(frame_cnt), 32'd1);

        // Paused launch: pause dropping right after launch must not matter.
        launch(1'b1);
        pause = 1'b0;
        wait_seq_done(100);
        check_eq("pause_frame", 32'(frame_cnt), 32'd2);

        // Overrun during WAIT on step 2, and one coinciding with step_done on step 3.
        launch(1'b0);
        wait_step(3'd2, 50);
        @(negedge clk);
        vblank_start = 1'b1;
        @(negedge clk);
        vblank_start = 1'b0;
        check_eq("overrun_set", 32'(overrun), 32'd1);
        wait_step(3'd3, 50);
        repeat (3) @(negedge clk);
        vblank_start = 1'b1;
        @(negedge clk);
        vblank_start = 1'b0;
        check_eq("coinc_next_go", 32'(step_go), 32'd1);
        wait_seq_done(100);
        check_eq("overrun_frame", 32'(frame_cnt), 32'd3);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_eq("overrun_clr", 32'(overrun), 32'd0);

        // Set and clear in the same cycle: set wins.
        launch(1'b1);
        vblank_start = 1'b1;
        clr_err = 1'b1;
        @(negedge clk);
        vblank_start = 1'b0;
        clr_err = 1'b0;
        check_eq("set_wins", 32'(overrun), 32'd1);
        wait_seq_done(100);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;

`ifdef PONG_SCHED_TIMEOUT_EN
        skip_en = 1'b1;
        skip_id = 3'd1;
        launch(1'b0);
        wait_step(3'd1, 50);
        repeat (16) @(negedge clk);
        check_eq("tmo_early", 32'(err_timeout), 32'd0);
        @(negedge clk);
        check_eq("tmo_set", 32'(err_timeout), 32'd1);
        check_eq("tmo_next_go", 32'(step_go), 32'd1);
        check_eq("tmo_next_id", 32'(step_id), 32'd2);
        skip_en = 1'b0;
        wait_seq_done(100);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_eq("tmo_clr", 32'(err_timeout), 32'd0);
`else
        check_eq("tmo_off", 32'(err_timeout), 32'd0);
`endif

        // Reset during WAIT on step 3, with a competing vblank that reset must override.
        launch(1'b0);
        wait_step(3'd1, 50);
        @(negedge clk);
        vblank_start = 1'b1;
        @(negedge clk);
        vblank_start = 1'b0;
        check_eq("pre_rst_overrun", 32'(overrun), 32'd1);
        wait_step(3'd3, 50);
        @(negedge clk);
        rst = 1'b1;
        vblank_start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vblank_start = 1'b0;
        step_q.delete();
        frame_q.delete();
        exp_frame = 8'd0;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_step_id", 32'(step_id), 32'd0);
        check_eq("mid_rst_step_go", 32'(step_go), 32'd0);
        check_eq("mid_rst_frame", 32'(frame_cnt), 32'd0);
        check_eq("mid_rst_overrun", 32'(overrun), 32'd0);
        check_eq("mid_rst_err", 32'(err_timeout), 32'd0);
        repeat (4) @(negedge clk);
        check_eq("late_done_ignored", 32'(busy), 32'd0);

        // 256 paused sequences: frame_cnt must wrap back to 0.
        ack_delay = 1;
        for (int i = 0; i < 256; i++) begin
            launch(1'b1);
            wait_seq_done(20);
        end
        check_eq("wrap_frame", 32'(frame_cnt), 32'd0);
        check_eq("sb_steps_drained", 32'(step_q.size()), 32'd0);
        check_eq("sb_frames_drained", 32'(frame_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
